// File: rtl/lbist_tpg_ctrl_if.sv
// ----------------------------------------------------------------------------
// lbist_tpg_ctrl_if
//   Session/pattern bundle between the LBIST pattern generator controller and
//   whatever drives it (test sequencer) and reads it (CUT harness, comp).
//
//   master : the controller (lbist_tpg_ctrl)
//     in  start     session request
//     in  hold      stall pattern/index while running
//     in  res       registered mismatch bit from comp (1 = mismatch)
//     out pat_out   current pattern, [0:PAT_BITS-1], bit 0 is the MSB
//     out pat_valid pat_out is a live test pattern
//     out busy      session in progress (RUN or DRAIN)
//     out done      one-cycle end-of-session pulse
//     out fail      sticky mismatch verdict
//     out fail_idx  index of the first failing pattern
//   slave  : the sequencer/harness side, directions mirrored
// ----------------------------------------------------------------------------
interface lbist_tpg_ctrl_if #(
    parameter int PAT_BITS = 4,
    parameter int CNT_W    = 4
);
    logic                start;
    logic                hold;
    logic                res;
    logic [0:PAT_BITS-1] pat_out;
    logic                pat_valid;
    logic                busy;
    logic                done;
    logic                fail;
    logic [CNT_W-1:0]    fail_idx;

    modport master (
        input  start, hold, res,
        output pat_out, pat_valid, busy, done, fail, fail_idx
    );

    modport slave (
        output start, hold, res,
        input  pat_out, pat_valid, busy, done, fail, fail_idx
    );
endinterface

// File: rtl/lbist_tpg_ctrl.sv
// ----------------------------------------------------------------------------
// lbist_tpg_ctrl
//   LBIST stimulus-side controller. On start it walks N_PATTERNS states of a
//   maximal-length LFSR onto pat_out, then folds the per-cycle mismatch bit
//   returned by comp into a sticky fail flag and the index of the first
//   failing pattern.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (aborts a session, no done)
//     bus    lbist_tpg_ctrl_if.master: start/hold/res in,
//            pat_out/pat_valid/busy/done/fail/fail_idx out
// ----------------------------------------------------------------------------
module lbist_tpg_ctrl #(
    parameter int                  PAT_BITS   = 4,
    parameter logic [0:PAT_BITS-1] TAPS       = 4'b1100,
    parameter logic [0:PAT_BITS-1] SEED       = 4'b0001,
    parameter int                  N_PATTERNS = 15,
    parameter int                  CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    lbist_tpg_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PATTERNS - 1);

    logic [1:0]          state;
    logic [0:PAT_BITS-1] pat;
    logic [CNT_W-1:0]    idx;
    logic                chk_valid;
    logic [CNT_W-1:0]    chk_idx;
    logic                fail;
    logic [CNT_W-1:0]    fail_idx;
    logic                run;
    logic                accept;

    // Fibonacci step: shift toward bit 0 (MSB), feedback enters at the LSB.
    function automatic logic [0:PAT_BITS-1] lfsr_step(input logic [0:PAT_BITS-1] p);
        logic fb;
        fb = ^(p & TAPS);
        return {p[1:PAT_BITS-1], fb};
    endfunction

    assign run    = (state == S_RUN);
    assign accept = (state == S_IDLE) && bus.start;

    // Stage 0: session FSM, pattern generator and pattern index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pat   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_RUN;
                        pat   <= SEED;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        // The last pattern is not stepped past; it simply
                        // stops being valid once we leave RUN.
                        if (idx == LAST_IDX) begin
                            state <= S_DRAIN;
                        end else begin
                            pat <= lfsr_step(pat);
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: align pattern index with comp's registered response, then
    // accumulate the verdict. A held pattern is rechecked every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_idx   <= '0;
            fail      <= 1'b0;
            fail_idx  <= '0;
        end else begin
            chk_valid <= run;
            chk_idx   <= idx;
            if (accept) begin
                fail     <= 1'b0;
                fail_idx <= '0;
            end else if (chk_valid && bus.res) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_idx <= chk_idx;
                end
            end
        end
    end

    assign bus.pat_out   = pat;
    assign bus.pat_valid = run;
    assign bus.busy      = run || (state == S_DRAIN);
    assign bus.done      = (state == S_DONE);
    assign bus.fail      = fail;
    assign bus.fail_idx  = fail_idx;

endmodule

// File: doc/lbist_tpg_ctrl.md
# lbist_tpg_ctrl

LBIST stimulus-side controller. It runs a test session on request, driving a maximal-length LFSR pattern sequence into the circuit under test and its fault-free reference. It then collects the per-cycle mismatch bit returned by the `comp` response analyser into a sticky pass/fail verdict, plus the index of the first failing pattern. It is the generating end of the pattern/response path whose checking end is `comp`.

## Interface
Parameters:
- `PAT_BITS`, default 4: LFSR/pattern width.
- `TAPS`, default 4'b1100: feedback tap mask, `[0 : PAT_BITS-1]` order.
- `SEED`, default 4'b0001: LFSR load value. Must be non-zero.
- `N_PATTERNS`, default 15: patterns per session. Range 1..2^`CNT_W`.
- `CNT_W`, default 4: pattern index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  session request. Sampled only in IDLE.
- `hold`  in  1  stall. Freezes pattern and index while in RUN.
- `res`  in  1  registered mismatch bit from `comp`: 1 = mismatch.
- `pat_out`  out  `[0 : PAT_BITS-1]`  current pattern. Bit 0 is the MSB.
- `pat_valid`  out  1  `pat_out` is a live test pattern.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at session end.
- `fail`  out  1  sticky mismatch flag. Cleared on an accepted `start`.
- `fail_idx`  out  `CNT_W`  index of the first failing pattern. Valid when `fail`=1.

## Operation
- Reset (async, `rst_n`=0): state IDLE. All outputs are 0: `pat_out`, `pat_valid`, `busy`, `done`, `fail`, `fail_idx`. Internal index, `chk_valid` and `chk_idx` are also 0.
- LFSR step: `fb = ^(pat & TAPS)`, then `pat_next = {pat[1 : PAT_BITS-1], fb}`. With the defaults this is period 15: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000.
- IDLE:
  - `start`=1 → RUN. At the same edge: `pat` ← `SEED`, idx ← 0, `fail` ← 0, `fail_idx` ← 0.
- RUN:
  - `pat_valid`=1 and `busy`=1.
  - If `hold`=0 and idx ≠ `N_PATTERNS`-1: step the LFSR and increment idx.
  - If `hold`=0 and idx = `N_PATTERNS`-1: → DRAIN, `pat_valid` ← 0. The LFSR does not step.
  - If `hold`=1: pattern and idx are unchanged.
- DRAIN: one cycle. `busy`=1, `pat_valid`=0, `hold` ignored. → DONE.
- DONE: one cycle. `done`=1, `busy`=0. → IDLE. `start` is ignored in this cycle.
- Response check:
  - `comp` registers its result, so `res` for the pattern shown in cycle k arrives in cycle k+1.
  - Delay register: `chk_valid` ← `pat_valid`, `chk_idx` ← idx, every cycle.
  - At each edge with `chk_valid`=1 and `res`=1: `fail` ← 1. If `fail` was 0, also `fail_idx` ← `chk_idx`.
  - `res` is ignored when `chk_valid`=0.
  - A held pattern is checked every cycle it is held.
- `start` in RUN, DRAIN or DONE has no effect.
- `fail` and `fail_idx` hold their values through IDLE until the next accepted `start`.

## Timing
- `start` is sampled at edge E0. Cycles are numbered after E0.
- With no hold:
  - Pattern i is shown in cycle i+1, for i = 0..`N_PATTERNS`-1.
  - DRAIN is cycle `N_PATTERNS`+1.
  - `done` is high in cycle `N_PATTERNS`+2.
  - Each `hold` cycle in RUN delays all of these by 1.
- `fail` and `fail_idx` are final when `done` is high.
- The response to the last pattern is captured at the end of DRAIN.
- Reset mid-session: abort immediately with all outputs at 0. No `done` is issued.

## Test plan
- Reset, pulse `start`, `hold`=0, `res`=0. Required: `pat_out` runs 0001, 0010, 0100, 1001 … 1000 in cycles 1–15; DRAIN in cycle 16; `done`=1 in cycle 17; `fail`=0.
- Same, with `res`=1 in cycle 7 and cycle 10. Required: `fail`=1 and `fail_idx`=5 at `done`; the later mismatch does not change `fail_idx`.
- `hold`=1 in cycles 3–5. Required: `pat_out`=0100 and idx 2 in cycles 3–6; 1001 in cycle 7; `done` in cycle 20.
- `res`=1 only in cycle 16 (DRAIN). Required: `fail`=1, `fail_idx`=14. `res`=1 in cycle 1 or cycle 17 has no effect.
- `start` pulsed in cycle 5 (RUN). Required: ignored, sequence unaffected. After `done`, a new `start` clears `fail` and restarts from 0001.
- `rst_n` driven low in cycle 8. Required: all outputs 0 without waiting for a clock edge. After release, stays in IDLE until `start`. `done` never pulses for the aborted session.
